// File: rtl/frame_sequencer.sv
// frame_sequencer: per-frame sequencing of a game-grid update followed by
// an LED refresh, with a fixed frame period measured by a saturating timer.
// Optional feature: define FRAME_TIMEOUT_EN to abort a stalled LED refresh
// after TIMEOUT_CYCLES cycles in WAIT_LED. Without it, WAIT_LED waits
// indefinitely and timeout is tied low.
`default_nettype none

module frame_sequencer #(
   parameter int unsigned FRAME_CYCLES   = 500000,
   parameter int unsigned GRID_CYCLES    = 2,
   parameter int unsigned TIMEOUT_CYCLES = 400000
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        run,
   input  logic        led_finished,
   input  logic        clear_flags,
   output logic        grid_enable,
   output logic        led_start,
   output logic        frame_done,
   output logic        busy,
   output logic        overrun,
   output logic        timeout,
   output logic [15:0] frame_count
);

   localparam int unsigned TW = $clog2(FRAME_CYCLES);
   localparam logic [TW-1:0] TIMER_LAST = TW'(FRAME_CYCLES - 1);
   localparam logic [TW-1:0] GRID_LAST  = TW'(GRID_CYCLES - 1);

   // Reject parameter sets that cannot fit grid, launch, wait and hold in a frame.
   if (GRID_CYCLES < 1 || FRAME_CYCLES < GRID_CYCLES + 4) begin : g_bad_frame
      $error("frame_sequencer: FRAME_CYCLES must be >= GRID_CYCLES+4, GRID_CYCLES >= 1");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("frame_sequencer: TIMEOUT_CYCLES must be >= 1");
   end

   typedef enum logic [2:0] {IDLE, GRID, LAUNCH, WAIT_LED, HOLD} state_e;

   state_e          state_q, state_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic [15:0]     frame_count_q;
   logic            grid_enable_q, grid_enable_d;
   logic            led_start_q, led_start_d;
   logic            frame_done_q, frame_done_d;
   logic            overrun_q, overrun_set;
   logic            timer_sat;
   logic            timeout_hit;

   assign timer_sat = (timer_q == TIMER_LAST);

   // State register plus the registered strobes derived from the next state.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         grid_enable_q <= 1'b0;
         led_start_q   <= 1'b0;
         frame_done_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q       <= state_d;
         grid_enable_q <= grid_enable_d;
         led_start_q   <= led_start_d;
         frame_done_q  <= frame_done_d;
      end
   end

   // Next-state logic; a refresh end (or hold expiry) chooses IDLE, GRID or HOLD.
   always_comb begin
      // NOTE: default first so no path leaves state_d unassigned (no latch).
      state_d = state_q;
      unique case (state_q)
         IDLE:     if (run) state_d = GRID;
         GRID:     if (timer_q == GRID_LAST) state_d = LAUNCH;
         LAUNCH:   state_d = WAIT_LED;
         WAIT_LED: begin
            if (led_finished || timeout_hit) begin
               if (!run)           state_d = IDLE;
               else if (timer_sat) state_d = GRID;
               else                state_d = HOLD;
            end
         end
         HOLD: begin
            if (!run)           state_d = IDLE;
            else if (timer_sat) state_d = GRID;
         end
         default:  state_d = IDLE;
      endcase
   end

   // Output decode: strobes are computed one cycle early and registered.
   always_comb begin
      grid_enable_d = (state_d == GRID);
      led_start_d   = (state_d == LAUNCH);
      frame_done_d  = (state_q == WAIT_LED) && led_finished;
   end

   // Frame timer: restart on GRID entry, count while busy, saturate at the frame end.
   always_comb begin
      timer_d = timer_q;
      if (state_d == GRID && state_q != GRID) begin
         timer_d = '0;
      end else if (state_q != IDLE && !timer_sat) begin
         timer_d = timer_q + TW'(1);
      end
      overrun_set = (state_d inside {GRID, LAUNCH, WAIT_LED}) && (timer_d == TIMER_LAST);
   end

   // Timer, completed-frame counter and sticky overrun flag (set beats clear).
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         timer_q       <= '0;
         frame_count_q <= '0;
         overrun_q     <= 1'b0;
      end else begin
         timer_q   <= timer_d;
         overrun_q <= overrun_set | (overrun_q & ~clear_flags);
         if (frame_done_d) frame_count_q <= frame_count_q + 16'd1;
      end
   end

`ifdef FRAME_TIMEOUT_EN
   localparam int unsigned DW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [DW-1:0] DWELL_LAST = DW'(TIMEOUT_CYCLES - 1);

   logic [DW-1:0] dwell_q;
   logic          timeout_q;

   assign timeout_hit = (state_q == WAIT_LED) && !led_finished && (dwell_q == DWELL_LAST);

   // WAIT_LED dwell counter and sticky timeout flag (set beats clear).
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         dwell_q   <= '0;
         timeout_q <= 1'b0;
      end else begin
         if (state_d == WAIT_LED && state_q != WAIT_LED) dwell_q <= '0;
         else if (state_q == WAIT_LED)                  dwell_q <= dwell_q + DW'(1);
         timeout_q <= timeout_hit | (timeout_q & ~clear_flags);
      end
   end

   assign timeout = timeout_q;
`else
   assign timeout_hit = 1'b0;
   assign timeout     = 1'b0;
`endif

   assign grid_enable = grid_enable_q;
   assign led_start   = led_start_q;
   assign frame_done  = frame_done_q;
   assign busy        = (state_q != IDLE);
   assign overrun     = overrun_q;
   assign frame_count = frame_count_q;

endmodule

`default_nettype wire

// File: tb/tb_frame_sequencer.sv
// Testbench for frame_sequencer: directed scenarios from the requirement
// examples plus randomized run/led_finished/clear_flags traffic, all checked
// every cycle against a frame-offset reference model.
`timescale 1ns/1ps

module tb_frame_sequencer;

   localparam int F  = 20;
   localparam int G  = 2;
   localparam int TO = 8;
`ifdef FRAME_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset_n, run, led_finished, clear_flags;
   logic        grid_enable, led_start, frame_done, busy, overrun, timeout;
   logic [15:0] frame_count;

   frame_sequencer #(.FRAME_CYCLES(F), .GRID_CYCLES(G), .TIMEOUT_CYCLES(TO)) dut (
      .clock(clock), .reset_n(reset_n), .run(run), .led_finished(led_finished),
      .clear_flags(clear_flags), .grid_enable(grid_enable), .led_start(led_start),
      .frame_done(frame_done), .busy(busy), .overrun(overrun), .timeout(timeout),
      .frame_count(frame_count)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;   // index of the cycle whose outputs are being observed

   // Reference model: a frame is described by its absolute start cycle.
   bit          m_active, m_done, m_fd, m_ovr, m_tmo;
   int          m_fstart;
   logic [15:0] m_cnt;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s cycle %0d: got %0h, expected %0h", tag, cyc, obs, exp);
   endtask

   function automatic int offs(input int c);
      return (c - m_fstart > F - 1) ? F - 1 : c - m_fstart;
   endfunction

   task automatic model_reset();
      m_active = 0; m_done = 0; m_fd = 0; m_ovr = 0; m_tmo = 0; m_cnt = '0; m_fstart = 0;
   endtask

   // Advance the model across the edge that ends cycle c.
   task automatic model_edge(input int c, input bit r, input bit lf, input bit clr);
      int  n = c + 1;
      bit  fd = 0, tmo_set = 0, ovr_set, decide = 0;
      int  off;
      if (!m_active) begin
         if (r) begin m_active = 1; m_fstart = n; m_done = 0; end
      end else begin
         off = offs(c);
         if (!m_done && off > G) begin
            if (lf) begin fd = 1; m_cnt = m_cnt + 16'd1; decide = 1; end
            else if (TMO_EN && (c - (m_fstart + G + 1)) == TO - 1) begin tmo_set = 1; decide = 1; end
         end else if (m_done) begin
            decide = 1;
         end
         if (decide) begin
            m_done = 1;
            if (!r)              m_active = 0;
            else if (off == F-1) begin m_fstart = n; m_done = 0; end
         end
      end
      ovr_set = m_active && !m_done && (offs(n) == F - 1);
      m_ovr = ovr_set ? 1'b1 : (clr ? 1'b0 : m_ovr);
      m_tmo = tmo_set ? 1'b1 : (clr ? 1'b0 : m_tmo);
      m_fd  = fd;
   endtask

   task automatic compare_all();
      check("grid_enable", grid_enable, m_active && (cyc - m_fstart) < G);
      check("led_start",   led_start,   m_active && (cyc - m_fstart) == G);
      check("frame_done",  frame_done,  m_fd);
      check("busy",        busy,        m_active);
      check("overrun",     overrun,     m_ovr);
      check("timeout",     timeout,     m_tmo);
      check("frame_count", frame_count, m_cnt);
   endtask

   // One clock cycle: drive inputs at the falling edge, check at the next one.
   task automatic step(input bit r, input bit lf, input bit clr);
      run = r; led_finished = lf; clear_flags = clr;
      @(posedge clock);
      model_edge(cyc, r, lf, clr);
      @(negedge clock);
      cyc++;
      compare_all();
   endtask

   // Asynchronous reset asserted between edges; outputs must clear at once.
   task automatic do_reset(input bit r);
      run = r; led_finished = 0; clear_flags = 0;
      reset_n = 0;
      #1;
      check("rst grid_enable", grid_enable, 0);
      check("rst led_start",   led_start,   0);
      check("rst frame_done",  frame_done,  0);
      check("rst busy",        busy,        0);
      check("rst overrun",     overrun,     0);
      check("rst timeout",     timeout,     0);
      check("rst frame_count", frame_count, 0);
      model_reset();
      repeat (2) @(negedge clock);
      reset_n = 1;
      cyc = 0;
   endtask

   initial begin
      reset_n = 1; run = 0; led_finished = 0; clear_flags = 0;
      @(negedge clock);

      // Nominal frame: grid 1-2, launch 3, done 7, next frame at 21.
      do_reset(1);
      for (int c = 0; c < 22; c++) begin
         step(1, c == 6, 0);
         if (cyc == 2)  check("grid@2", grid_enable, 1);
         if (cyc == 3)  check("led_start@3", led_start, 1);
         if (cyc == 7)  check("frame_done@7", frame_done, 1);
         if (cyc == 7)  check("count@7", frame_count, 16'd1);
         if (cyc == 21) check("grid@21", grid_enable, 1);
      end

`ifdef FRAME_TIMEOUT_EN
      // Stalled refresh: timeout after WAIT_LED cycles 4-11, clear loses to set.
      do_reset(1);
      for (int c = 0; c < 22; c++) begin
         step(1, 0, c == 11 || c == 15);
         if (cyc == 12) check("timeout@12", timeout, 1);
         if (cyc == 12) check("busy@12", busy, 1);
         if (cyc == 16) check("timeout cleared", timeout, 0);
         if (cyc == 21) check("grid@21 tmo", grid_enable, 1);
         if (cyc == 21) check("count tmo", frame_count, 16'd0);
      end
`else
      // Late refresh: overrun at 20 despite clear in 19, restart at 26, lone clear.
      do_reset(1);
      for (int c = 0; c < 32; c++) begin
         step(1, c == 25, c == 19 || c == 30);
         if (cyc == 20) check("overrun@20", overrun, 1);
         if (cyc == 26) check("frame_done@26", frame_done, 1);
         if (cyc == 26) check("grid@26", grid_enable, 1);
         if (cyc == 31) check("overrun cleared", overrun, 0);
      end
`endif

      // run dropped mid-refresh: frame completes then IDLE.
      do_reset(1);
      for (int c = 0; c < 14; c++) begin
         step(c < 5, c == 6, 0);
         if (cyc == 7) check("stop frame_done@7", frame_done, 1);
         if (cyc == 7) check("stop busy@7", busy, 0);
      end

      // Reset in mid-GRID, then restart.
      do_reset(1);
      step(1, 0, 0);
      step(1, 0, 0);
      do_reset(1);
      for (int c = 0; c < 4; c++) begin
         step(1, 0, 0);
         if (cyc == 1) check("restart grid@1", grid_enable, 1);
      end

      // Randomized traffic with occasional resets.
      for (int seg = 0; seg < 40; seg++) begin
         int lf_den  = (seg % 3 == 0) ? 2 : ((seg % 3 == 1) ? 6 : 24);
         int run_den = $urandom_range(4, 40);
         if ($urandom_range(0, 3) == 0) do_reset($urandom_range(0, 1));
         for (int c = 0; c < 60; c++) begin
            step($urandom_range(0, run_den - 1) != 0,
                 $urandom_range(0, lf_den - 1) == 0,
                 $urandom_range(0, 15) == 0);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
